processor_param: RTL and testbench

Parametrised accumulator processor: the next generation of the team's 8-bit simple processor. It keeps the 3-bit-opcode accumulator ISA and the `enter`-gated input. It adds:
- configurable data width and memory depth;
- an on-chip program/data memory with an external load port and a `start` handshake;
- edge-qualified input;
- an explicit OUT instruction with a valid strobe;
- shift operations.

It sits at top level between the board switches/buttons and the display.

---
 rtl/processor_param.sv | 153 +++++++++++++++
 tb/tb_processor_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_param.sv
// rtl/processor_param.sv - parametrised accumulator processor with on-chip program/data memory
// Two-cycle FETCH/EXEC core with a LOAD/HALT window for external memory writes and restart.
module processor_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              start,
  input  logic              loadWe,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [DATA_W-1:0] loadData,
  output logic [DATA_W-1:0] dataOut,
  output logic              outValid,
  output logic              waiting,
  output logic              halt
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] OP_LDA  = 3'b000;
  localparam logic [2:0] OP_STA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_IN   = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_JPOS = 3'b110;
  localparam logic [2:0] OP_SYS  = 3'b111;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_INPUT,
    S_HALT
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_a;
  logic [ADDR_W-1:0]   r_pc;
  logic [2:0]          r_ir_op;
  logic [ADDR_W-1:0]   r_ir_addr;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_out_valid;
  logic                r_enter_prev;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

  logic                w_idle;
  logic [DATA_W-1:0]   w_operand;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  assign w_idle    = (r_state == S_LOAD) || (r_state == S_HALT);
  assign w_operand = r_mem[r_ir_addr];

  // Load port and STA share the single write port; they can never collide since
  // the load port is only live while the core is idle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = loadAddr;
    w_mem_wdata = loadData;
    if (w_idle && loadWe) begin
      w_mem_we = 1'b1;
    end else if ((r_state == S_EXEC) && (r_ir_op == OP_STA)) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_ir_addr;
      w_mem_wdata = r_a;
    end
  end

  // No reset here so a loaded program survives reset; an asynchronous reset drops
  // the state out of EXEC before the edge, which suppresses an in-flight STA.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_a          <= '0;
      r_pc         <= '0;
      r_ir_op      <= '0;
      r_ir_addr    <= '0;
      r_data_out   <= '0;
      r_out_valid  <= 1'b0;
      r_enter_prev <= 1'b0;
    end else begin
      r_enter_prev <= enter;
      r_out_valid  <= 1'b0;
      case (r_state)
        S_LOAD, S_HALT: begin
          if (start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir_op   <= r_mem[r_pc][DATA_W-1 -: 3];
          r_ir_addr <= r_mem[r_pc][ADDR_W-1:0];
          r_pc      <= r_pc + 1'b1;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (r_ir_op)
            OP_LDA:  r_a <= w_operand;
            OP_STA:  ;
            OP_ADD:  r_a <= r_a + w_operand;
            OP_SUB:  r_a <= r_a - w_operand;
            OP_IN:   r_state <= S_INPUT;
            OP_JZ: begin
              if (r_a == '0) r_pc <= r_ir_addr;
            end
            OP_JPOS: begin
              if (!r_a[DATA_W-1] && (r_a != '0)) r_pc <= r_ir_addr;
            end
            OP_SYS: begin
              case (r_ir_addr[1:0])
                2'b00: r_state <= S_HALT;
                2'b01: begin
                  r_data_out  <= r_a;
                  r_out_valid <= 1'b1;
                end
                2'b10: r_a <= r_a << 1;
                2'b11: r_a <= r_a >> 1;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        S_INPUT: begin
          if (enter && !r_enter_prev) begin
            r_a     <= dataIn;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign dataOut  = r_data_out;
  assign outValid = r_out_valid;
  assign waiting  = (r_state == S_INPUT);
  assign halt     = (r_state == S_HALT);

endmodule

// File: tb/tb_processor_param.sv
// tb/tb_processor_param.sv - directed table-driven bench for processor_param
// Runs small programs on an 8/5 instance and a 12/7 instance, checking OUT values and halt timing.
module tb_processor_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        enter, start, loadWe;
  logic [7:0]  dataIn, loadData, dataOut;
  logic [4:0]  loadAddr;
  logic        outValid, waiting, halt;

  logic        enter2, start2, loadWe2;
  logic [11:0] dataIn2, loadData2, dataOut2;
  logic [6:0]  loadAddr2;
  logic        outValid2, waiting2, halt2;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]  outs[$];
  logic [11:0] outs2[$];

  always #5 clock = ~clock;

  processor_param #(.DATA_W(8), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .enter(enter), .dataIn(dataIn), .start(start),
    .loadWe(loadWe), .loadAddr(loadAddr), .loadData(loadData),
    .dataOut(dataOut), .outValid(outValid), .waiting(waiting), .halt(halt)
  );

  processor_param #(.DATA_W(12), .ADDR_W(7)) dut2 (
    .clock(clock), .reset(reset), .enter(enter2), .dataIn(dataIn2), .start(start2),
    .loadWe(loadWe2), .loadAddr(loadAddr2), .loadData(loadData2),
    .dataOut(dataOut2), .outValid(outValid2), .waiting(waiting2), .halt(halt2)
  );

  always @(negedge clock) begin
    if (outValid)  outs.push_back(dataOut);
    if (outValid2) outs2.push_back(dataOut2);
  end

  typedef struct {
    string      name;
    logic [7:0] a0;
    logic [7:0] instr;
    logic [7:0] opnd;
    logic [7:0] exp;
  } alu_vec_t;

  typedef struct {
    string      name;
    logic [7:0] instr;
    logic [7:0] a0;
    logic [7:0] exp;
  } jmp_vec_t;

  alu_vec_t alu_tbl[7];
  jmp_vec_t jmp_tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int q_at(input int i);
    if (i < outs.size()) return int'(outs[i]);
    return -1;
  endfunction

  function automatic int q2_at(input int i);
    if (i < outs2.size()) return int'(outs2[i]);
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    loadAddr = a;
    loadData = d;
    loadWe   = 1'b1;
    tick();
    loadWe   = 1'b0;
  endtask

  task automatic load2(input logic [6:0] a, input logic [11:0] d);
    loadAddr2 = a;
    loadData2 = d;
    loadWe2   = 1'b1;
    tick();
    loadWe2   = 1'b0;
  endtask

  // inj >= 0 drives a stray write to mem[30] plus start at that cycle of the run
  task automatic run(input int inj, output int cyc);
    outs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 500) begin
      if (cyc == inj) begin
        loadWe = 1'b1; loadAddr = 5'd30; loadData = 8'd99; start = 1'b1;
      end
      tick();
      cyc++;
      loadWe = 1'b0;
      start  = 1'b0;
      if (halt) break;
    end
    if (!halt) check("run_timeout", 0, 1);
  endtask

  function automatic logic [11:0] enc2(input logic [2:0] op, input logic [6:0] a);
    return {op, 2'b00, a};
  endfunction

  initial begin
    int cyc;

    alu_tbl[0] = '{"add_wrap",  8'd250, 8'h5D, 8'd10,  8'd4};
    alu_tbl[1] = '{"sub_wrap",  8'd4,   8'h7D, 8'd5,   8'd255};
    alu_tbl[2] = '{"shr",       8'd255, 8'hFF, 8'd0,   8'd127};
    alu_tbl[3] = '{"shl",       8'h81,  8'hE2, 8'd0,   8'h02};
    alu_tbl[4] = '{"add_plain", 8'd5,   8'h5D, 8'd7,   8'd12};
    alu_tbl[5] = '{"sub_zero",  8'd9,   8'h7D, 8'd9,   8'd0};
    alu_tbl[6] = '{"lda",       8'd0,   8'h1D, 8'h5A,  8'h5A};

    jmp_tbl[0] = '{"jpos_neg",  8'hC5, 8'd255, 8'h11};
    jmp_tbl[1] = '{"jpos_pos",  8'hC5, 8'd127, 8'h22};
    jmp_tbl[2] = '{"jpos_zero", 8'hC5, 8'd0,   8'h11};
    jmp_tbl[3] = '{"jpos_msb",  8'hC5, 8'h80,  8'h11};
    jmp_tbl[4] = '{"jpos_one",  8'hC5, 8'd1,   8'h22};
    jmp_tbl[5] = '{"jz_zero",   8'hA5, 8'd0,   8'h22};
    jmp_tbl[6] = '{"jz_nonz",   8'hA5, 8'd1,   8'h11};

    reset = 1'b0; enter = 1'b0; start = 1'b0; loadWe = 1'b0;
    dataIn = '0; loadAddr = '0; loadData = '0;
    enter2 = 1'b0; start2 = 1'b0; loadWe2 = 1'b0;
    dataIn2 = '0; loadAddr2 = '0; loadData2 = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_dataOut", dataOut, 0);
    check("rst_outValid", outValid, 0);
    check("rst_waiting", waiting, 0);
    check("rst_halt", halt, 0);

    load(0, 8'h1E); load(1, 8'h5F); load(2, 8'hE1); load(3, 8'hE0);
    load(30, 8'd5); load(31, 8'd7);
    run(-1, cyc);
    check("basic_out_count", outs.size(), 1);
    check("basic_out", q_at(0), 12);
    check("basic_halt_cycles", cyc, 8);

    run(3, cyc);
    check("inject_out", q_at(0), 12);
    check("inject_halt_cycles", cyc, 8);
    run(-1, cyc);
    check("inject_mem_intact", q_at(0), 12);

    for (int i = 0; i < 7; i++) begin
      load(0, 8'h1C); load(1, alu_tbl[i].instr); load(2, 8'hE1); load(3, 8'hE0);
      load(28, alu_tbl[i].a0); load(29, alu_tbl[i].opnd);
      run(-1, cyc);
      check({alu_tbl[i].name, "_out"}, q_at(0), int'(alu_tbl[i].exp));
      check({alu_tbl[i].name, "_count"}, outs.size(), 1);
      check({alu_tbl[i].name, "_cycles"}, cyc, 8);
    end

    load(0, 8'h1C); load(2, 8'h1D); load(3, 8'hE1); load(4, 8'hE0);
    load(5, 8'h1B); load(6, 8'hE1); load(7, 8'hE0);
    load(27, 8'h22); load(29, 8'h11);
    for (int i = 0; i < 7; i++) begin
      load(1, jmp_tbl[i].instr); load(28, jmp_tbl[i].a0);
      run(-1, cyc);
      check(jmp_tbl[i].name, q_at(0), int'(jmp_tbl[i].exp));
    end

    load(0, 8'h1C); load(1, 8'h7D); load(2, 8'hE1); load(3, 8'hA5);
    load(4, 8'hC1); load(5, 8'hE0); load(28, 8'd3); load(29, 8'd1);
    run(-1, cyc);
    check("loop_count", outs.size(), 3);
    check("loop_it1", q_at(0), 2);
    check("loop_it2", q_at(1), 1);
    check("loop_it3", q_at(2), 0);
    check("loop_cycles", cyc, 26);

    load(0, 8'h80); load(1, 8'hE1); load(2, 8'h80); load(3, 8'hE1); load(4, 8'hE0);
    outs.delete();
    enter = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("in_wait_rise", waiting, 1);
    repeat (4) tick();
    check("in_held_enter", waiting, 1);
    enter = 1'b0; tick();
    dataIn = 8'h3C; enter = 1'b1; tick();
    check("in_wait_fall", waiting, 0);
    repeat (4) tick();
    check("in_second_wait", waiting, 1);
    repeat (4) tick();
    check("in_second_needs_edge", waiting, 1);
    check("in_first_out", q_at(0), 8'h3C);
    check("in_first_count", outs.size(), 1);
    enter = 1'b0; tick();
    dataIn = 8'h5A; enter = 1'b1; tick();
    for (int k = 0; k < 20 && !halt; k++) tick();
    check("in_halt", halt, 1);
    check("in_second_out", q_at(1), 8'h5A);
    enter = 1'b0;

    load(0, 8'h1D); load(1, 8'hE1); load(2, 8'h1E); load(3, 8'h3D); load(4, 8'hE0);
    load(29, 8'h77); load(30, 8'd5);
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    reset = 1'b0;
    #1;
    check("rst_mid_dataOut", dataOut, 0);
    check("rst_mid_outValid", outValid, 0);
    check("rst_mid_waiting", waiting, 0);
    check("rst_mid_halt", halt, 0);
    tick();
    reset = 1'b1;
    tick();
    run(-1, cyc);
    check("rerun_out", q_at(0), 8'h77);
    check("rerun_cycles", cyc, 10);
    run(-1, cyc);
    check("sta_written", q_at(0), 5);

    load2(0, enc2(3'd5, 7'd120)); load2(1, enc2(3'd7, 7'd1)); load2(2, enc2(3'd7, 7'd0));
    load2(120, enc2(3'd0, 7'd100)); load2(121, {3'd2, 2'b11, 7'd101});
    load2(122, enc2(3'd7, 7'd1)); load2(123, enc2(3'd7, 7'd2));
    load2(124, enc2(3'd7, 7'd1)); load2(125, enc2(3'd3, 7'd102));
    load2(126, enc2(3'd7, 7'd1)); load2(127, enc2(3'd7, 7'd3));
    load2(100, 12'h123); load2(101, 12'h456); load2(102, 12'hFF0);
    outs2.delete();
    start2 = 1'b1; tick(); start2 = 1'b0;
    cyc = 0;
    while (cyc < 500 && !halt2) begin
      tick();
      cyc++;
    end
    check("wide_halt", halt2, 1);
    check("wide_cycles", cyc, 24);
    check("wide_count", outs2.size(), 4);
    check("wide_add", q2_at(0), 12'h579);
    check("wide_shl", q2_at(1), 12'hAF2);
    check("wide_sub", q2_at(2), 12'hB02);
    check("wide_shr_wrap", q2_at(3), 12'h581);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
